// File: rtl/rr_arbiter4_pkg.sv
// Shared types and defaults for the four-way round-robin arbiter.
// Includes the state encoding, the requester count and default hold limits.
package rr_arbiter4_pkg;

  localparam int NUM_REQ      = 4;
  localparam int DEF_MAX_HOLD = 4;
  localparam int DEF_CNT_W    = 4;

  typedef logic [1:0] idx_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter4_if import rr_arbiter4_pkg::*; ();

  logic [NUM_REQ-1:0] req;
  logic               stall;
  idx_t               grant_idx;
  logic               grant_valid;

  modport master (
    output req,
    output stall,
    input  grant_idx,
    input  grant_valid
  );

  modport slave (
    input  req,
    input  stall,
    output grant_idx,
    output grant_valid
  );

endinterface

// File: rtl/rr_arbiter4_pick.sv
// Combinational round-robin pick: first active request after ref_ptr,
// wrapping, with ref_ptr itself examined last.
module rr_pick4 import rr_arbiter4_pkg::*; (
  input  logic [NUM_REQ-1:0] req,
  input  idx_t               ref_ptr,
  output idx_t               win_idx,
  output logic               any
);

  idx_t               base;
  idx_t               off;
  logic [NUM_REQ-1:0] rot;

  assign base = ref_ptr + 2'd1;

  // rot[0] is the highest-priority candidate, rot[3] is ref_ptr itself
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    assign rot[gi] = req[2'(base + 2'(gi))];
  end

  always_comb begin
    off = 2'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = 2'(i);
    end
  end

  assign any     = |req;
  assign win_idx = base + off;

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with bounded grant hold; drives the
// select/enable pair for an external 2-to-4 decoder.
module rr_arbiter4 import rr_arbiter4_pkg::*; #(
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic         clock,
  input  logic         resetn,
  rr_arbiter4_if.slave arb
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

  arb_state_e       state_reg,     state_next;
  idx_t             grant_idx_reg, grant_idx_next;
  idx_t             last_ptr_reg,  last_ptr_next;
  logic [CNT_W-1:0] hold_cnt_reg,  hold_cnt_next;

  idx_t ref_ptr;
  idx_t win_idx;
  logic any;

  // While granting, rotate past the current holder; while idle, past the last one
  assign ref_ptr = (state_reg == ST_GRANT) ? grant_idx_reg : last_ptr_reg;

  rr_pick4 u_pick (
    .req     (arb.req),
    .ref_ptr (ref_ptr),
    .win_idx (win_idx),
    .any     (any)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= ST_IDLE;
      grant_idx_reg <= 2'd0;
      last_ptr_reg  <= 2'd3;
      hold_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      grant_idx_reg <= grant_idx_next;
      last_ptr_reg  <= last_ptr_next;
      hold_cnt_reg  <= hold_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    grant_idx_next = grant_idx_reg;
    last_ptr_next  = last_ptr_reg;
    hold_cnt_next  = hold_cnt_reg;
    if (!arb.stall) begin
      case (state_reg)
        ST_IDLE: begin
          if (any) begin
            state_next     = ST_GRANT;
            grant_idx_next = win_idx;
            hold_cnt_next  = HOLD_ONE;
          end
        end
        ST_GRANT: begin
          if (arb.req[grant_idx_reg] && (hold_cnt_reg < HOLD_MAX)) begin
            hold_cnt_next = hold_cnt_reg + HOLD_ONE;
          end else if (!any) begin
            state_next    = ST_IDLE;
            last_ptr_next = grant_idx_reg;
            hold_cnt_next = '0;
          end else begin
            // A sole requester at the hold limit wins its own search again
            grant_idx_next = win_idx;
            hold_cnt_next  = HOLD_ONE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign arb.grant_idx   = grant_idx_reg;
  assign arb.grant_valid = (state_reg == ST_GRANT);

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: default build (MAX_HOLD=4) and a MAX_HOLD=1 build.
module tb_rr_arbiter4;

  logic clock;
  logic resetn;
  int   n_checks;
  int   n_pass;
  int   cyc;

  rr_arbiter4_if bus  ();
  rr_arbiter4_if bus1 ();

  rr_arbiter4 #(.MAX_HOLD(4), .CNT_W(4)) u_dut (
    .clock  (clock),
    .resetn (resetn),
    .arb    (bus.slave)
  );

  rr_arbiter4 #(.MAX_HOLD(1), .CNT_W(4)) u_dut1 (
    .clock  (clock),
    .resetn (resetn),
    .arb    (bus1.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    $display("cyc %0d req=%b stall=%b idx=%0d valid=%b | req1=%b idx1=%0d valid1=%b",
             cyc, bus.req, bus.stall, bus.grant_idx, bus.grant_valid,
             bus1.req, bus1.grant_idx, bus1.grant_valid);
  endtask

  task automatic expect_grant(input string tag, input int idx, input logic valid);
    check({tag, "_idx"}, 32'(bus.grant_idx), 32'(idx));
    check({tag, "_valid"}, 32'(bus.grant_valid), 32'(valid));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    resetn    = 1'b1;
    bus.req   = 4'b0000;
    bus.stall = 1'b0;
    bus1.req   = 4'b0000;
    bus1.stall = 1'b0;
    #2 resetn = 1'b0;
    step();
    step();
    expect_grant("reset_state", 0, 1'b0);
    resetn  = 1'b1;

    // 1: grant moves to idx1 after four cycles, then async reset mid-grant
    bus.req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      step();
      expect_grant($sformatf("pre_rst_%0d", k), (k < 4) ? 0 : 1, 1'b1);
    end
    resetn = 1'b0;
    #1;
    expect_grant("async_rst", 0, 1'b0);
    step();
    expect_grant("held_rst", 0, 1'b0);
    resetn = 1'b1;

    // 2: full rotation with all requesters active
    for (int g = 0; g <= 16; g++) begin
      step();
      expect_grant($sformatf("rot_%0d", g), (g / 4) % 4, 1'b1);
    end

    // 3: early release and idle pointer
    bus.req = 4'b0010;
    step();
    expect_grant("early_idx1", 1, 1'b1);
    bus.req = 4'b1100;
    step();
    expect_grant("early_idx2", 2, 1'b1);
    bus.req = 4'b0000;
    step();
    expect_grant("to_idle", 2, 1'b0);
    bus.req = 4'b0110;
    step();
    expect_grant("idle_wrap", 1, 1'b1);

    // 4: sole requester keeps grant across hold-limit boundaries
    bus.req = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      step();
      expect_grant($sformatf("sole_%0d", k), 2, 1'b1);
    end

    // 5: stall at hold_cnt=2 with a request change
    bus.stall = 1'b1;
    bus.req   = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      step();
      expect_grant($sformatf("stall_%0d", k), 2, 1'b1);
    end
    bus.stall = 1'b0;
    step();
    expect_grant("unstall", 0, 1'b1);

    // hold counter must not advance while stalled
    bus.req = 4'b0101;
    step();
    expect_grant("hold2", 0, 1'b1);
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      expect_grant($sformatf("stall_hold_%0d", k), 0, 1'b1);
    end
    bus.stall = 1'b0;
    step();
    expect_grant("hold3", 0, 1'b1);
    step();
    expect_grant("hold4", 0, 1'b1);
    step();
    expect_grant("hold_expire", 2, 1'b1);

    // 6: MAX_HOLD=1 build alternates every cycle
    bus1.req = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      logic [3:0] onehot;
      step();
      onehot = 4'(1 << bus1.grant_idx);
      check($sformatf("mh1_idx_%0d", k), 32'(bus1.grant_idx), (k % 2 == 0) ? 32'd1 : 32'd3);
      check($sformatf("mh1_valid_%0d", k), 32'(bus1.grant_valid), 32'd1);
      check($sformatf("mh1_onehot_%0d", k), 32'(onehot), (k % 2 == 0) ? 32'h2 : 32'h8);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
